// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer
// Streams a burst of words out of the registered-read operand ROM onto a
// valid/ready interface. A 2-entry skid FIFO plus an in-flight read credit
// hides the ROM's one-cycle latency. Downstream stalls never overflow the FIFO.

module rom_fetch_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [ADDR_W:0] LEN_MAX = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One skid-FIFO slot: the word plus its burst position and end marker.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   idx;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_sel;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   wr_idx_q;
  logic              rd_pending_q;
  entry_t            fifo_q [2];
  logic              head_q;
  logic [1:0]        count_q;
  logic [1:0]        count_next;

  logic              accept;
  logic              flush;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;

  assign accept = (state_q == IDLE) && start && !abort;
  assign flush  = (state_q != IDLE) && abort;
  assign pop    = out_valid && out_ready;
  // A returning read lands in the FIFO unless the burst is being cancelled.
  assign push   = rd_pending_q && !flush;

  // Slots already committed after this edge's pop; a new read needs one free.
  assign occupancy  = 3'(count_q) + 3'(rd_pending_q) - 3'(pop);
  assign issue      = (state_q == FETCH) && !abort && (occupancy < 3'd2) &&
                      (issued_q < len_q);
  assign count_next = count_q + 2'(push) - 2'(pop);

  // Burst length: 0 selects a full ROM sweep, oversize requests saturate.
  always_comb begin
    // NOTE: default first so every path assigns len_sel and no latch is inferred.
    len_sel = num_words;
    if ((num_words == '0) || (num_words > LEN_MAX)) len_sel = LEN_MAX;
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (issue && ((issued_q + LEN_ONE) == len_q)) state_d = DRAIN;
      DRAIN:   if (!rd_pending_q && (count_next == 2'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register, ROM address, burst counters and the in-flight read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      wr_idx_q     <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      rd_pending_q <= issue;
      if (accept) begin
        rom_addr_q <= start_addr;
        len_q      <= len_sel;
        issued_q   <= '0;
        wr_idx_q   <= '0;
      end else begin
        // Address wraps naturally because DEPTH is a power of two.
        if (issue) begin
          rom_addr_q <= rom_addr_q + 1'b1;
          issued_q   <= issued_q + LEN_ONE;
        end
        if (push) wr_idx_q <= wr_idx_q + LEN_ONE;
      end
    end
  end

  // Two-entry skid FIFO: write behind the head, pop advances the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, since the head slot drives out_data directly.
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      // The credit rule keeps count below 2 whenever a write arrives.
      if (push) begin
        fifo_q[head_q ^ count_q[0]] <= '{data: rom_data,
                                         idx:  wr_idx_q,
                                         last: (wr_idx_q == (len_q - LEN_ONE))};
      end
      if (pop) head_q <= ~head_q;
      count_q <= count_next;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[head_q].data;
  assign out_idx   = fifo_q[head_q].idx;
  assign out_last  = fifo_q[head_q].last;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb_rom_fetch_sequencer
// Directed bench for rom_fetch_sequencer with a registered-read ROM model.

module tb_rom_fetch_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int BEAT_W = DATA_W + ADDR_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   num_words = '0;
  logic              busy, done, out_valid, out_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W:0]   out_idx;
  logic [DATA_W-1:0] rom_data, out_data;
  logic [DATA_W-1:0] rom [DEPTH];
  logic [BEAT_W-1:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  rom_fetch_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Operand ROM: one-cycle registered read.
  always @(posedge clk) rom_data <= rom[rom_addr];

  assign obs = {out_valid, out_last, out_idx, out_data};

  function automatic logic [BEAT_W-1:0] beat(input logic last, input logic [ADDR_W:0] idx,
                                             input logic [DATA_W-1:0] d);
    return {1'b1, last, idx, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    start_addr = a;
    num_words  = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
    end
    n_checks++;
    if ({rom_addr, out_idx, out_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%0d idx=%0d data=%h expected all 0", rom_addr, out_idx, out_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_burst();
    out_ready = 1'b1;
    pulse_start(3'd0, 4'd0);
    n_checks++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL full_e0: got busy/valid=%b expected 10", {busy, out_valid});
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_e1_valid: got %b expected 0", out_valid);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== beat(k == 7, 4'(k), rom[k]) || done !== 1'b0) begin
        n_fail++; $display("FAIL full_beat%0d: got %h done=%b expected %h done=0", k, obs, done, beat(k == 7, 4'(k), rom[k]));
      end
      step();
    end
    n_checks++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL full_done: got done/busy/valid=%b expected 100", {done, busy, out_valid});
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL full_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr [3];
    logic [DATA_W-1:0] exp_word [3];
    exp_addr = '{3'd6, 3'd7, 3'd0};
    exp_word = '{32'h41577C84, 32'h41EEC4D0, 32'h41633404};
    out_ready = 1'b1;
    pulse_start(3'd6, 4'd3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rom_addr !== exp_addr[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, rom_addr, exp_addr[i]);
      end
      if (i < 2) step();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== beat(i == 2, 4'(i), exp_word[i])) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %h expected %h", i, obs, beat(i == 2, 4'(i), exp_word[i]));
      end
      step();
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_done: got done/busy=%b expected 10", {done, busy});
    end
    step();
  endtask

  task automatic test_backpressure();
    int k = 0;
    int issues = 0;
    bit held = 1'b0;
    bit fin = 1'b0;
    logic [BEAT_W-1:0] held_obs = '0;
    logic [ADDR_W-1:0] prev_addr;
    out_ready = 1'b0;
    pulse_start(3'd0, 4'd12);
    prev_addr = rom_addr;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (rom_addr !== prev_addr) issues++;
      prev_addr = rom_addr;
      n_checks++;
      if (issues - k > 2) begin
        n_fail++; $display("FAIL bp_credit: got %0d reads ahead expected at most 2", issues - k);
      end
      if (held) begin
        n_checks++;
        if (obs !== held_obs) begin
          n_fail++; $display("FAIL bp_stable: got %h expected %h", obs, held_obs);
        end
      end
      if (done === 1'b1) begin
        fin = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        held      = out_valid && !out_ready;
        held_obs  = obs;
        if (out_valid && out_ready) begin
          n_checks++;
          if (obs !== beat(k == 7, 4'(k), rom[k % DEPTH])) begin
            n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", k, obs, beat(k == 7, 4'(k), rom[k % DEPTH]));
          end
          k++;
        end
        step();
      end
    end
    n_checks++;
    if (!fin || k != 8) begin
      n_fail++; $display("FAIL bp_count: got %0d words done=%0d expected 8 words and done", k, fin);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_stall_start();
    out_ready = 1'b0;
    pulse_start(3'd0, 4'd8);
    repeat (10) step();
    n_checks++;
    if (rom_addr !== 3'd2) begin
      n_fail++; $display("FAIL stall_issued: got rom_addr %0d expected 2", rom_addr);
    end
    n_checks++;
    if (obs !== beat(1'b0, 4'd0, rom[0])) begin
      n_fail++; $display("FAIL stall_head: got %h expected %h", obs, beat(1'b0, 4'd0, rom[0]));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== beat(k == 7, 4'(k), rom[k])) begin
        n_fail++; $display("FAIL stall_beat%0d: got %h expected %h", k, obs, beat(k == 7, 4'(k), rom[k]));
      end
      step();
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL stall_done: got done/busy=%b expected 10", {done, busy});
    end
    step();
  endtask

  task automatic test_abort();
    int hs = 0;
    out_ready = 1'b0;
    pulse_start(3'd0, 4'd8);
    for (int cyc = 0; cyc < 50 && hs < 3; cyc++) begin
      out_ready = 1'(cyc % 2);
      if (out_valid && out_ready) hs++;
      step();
    end
    n_checks++;
    if (hs != 3) begin
      n_fail++; $display("FAIL abort_handshakes: got %0d expected 3", hs);
    end
    abort     = 1'b1;
    out_ready = 1'b0;
    step();
    abort = 1'b0;
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL abort_flush: got valid/busy/done=%b expected 000", {out_valid, busy, done});
    end
    step();
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL abort_no_done: got valid/busy/done=%b expected 000", {out_valid, busy, done});
    end
    // abort alongside start in IDLE keeps the block idle
    abort = 1'b1;
    pulse_start(3'd2, 4'd4);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_beats_start: got busy %b expected 0", busy);
    end
    out_ready = 1'b1;
    pulse_start(3'd5, 4'd1);
    step();
    step();
    n_checks++;
    if (obs !== beat(1'b1, 4'd0, 32'h41BC8D1B)) begin
      n_fail++; $display("FAIL abort_restart: got %h expected %h", obs, beat(1'b1, 4'd0, 32'h41BC8D1B));
    end
    step();
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL abort_restart_done: got done/busy=%b expected 10", {done, busy});
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    pulse_start(3'd3, 4'd8);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
    end
    n_checks++;
    if ({rom_addr, out_idx, out_data} !== '0) begin
      n_fail++; $display("FAIL areset_data: got addr=%0d idx=%0d data=%h expected all 0", rom_addr, out_idx, out_data);
    end
    #7 rst_n = 1'b1;
    step();
    pulse_start(3'd0, 4'd8);
    // second start while busy must be ignored
    start_addr = 3'd5;
    num_words  = 4'd1;
    start      = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL areset_e1: got busy/valid=%b expected 10", {busy, out_valid});
    end
    step();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== beat(k == 7, 4'(k), rom[k])) begin
        n_fail++; $display("FAIL areset_beat%0d: got %h expected %h", k, obs, beat(k == 7, 4'(k), rom[k]));
      end
      step();
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL areset_done: got done/busy=%b expected 10", {done, busy});
    end
    step();
  endtask

  initial begin
    rom[0] = 32'h41633404;
    rom[1] = 32'h41200000;
    rom[2] = 32'h3F800000;
    rom[3] = 32'h40490FDB;
    rom[4] = 32'hC0000000;
    rom[5] = 32'h41BC8D1B;
    rom[6] = 32'h41577C84;
    rom[7] = 32'h41EEC4D0;
    test_reset();
    test_full_burst();
    test_wrap();
    test_backpressure();
    test_stall_start();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
